// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device command path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    XFER,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_START_TO  = 2'b01;
  localparam logic [1:0] ERR_PACKET_TO = 2'b10;
  localparam logic [1:0] ERR_NO_ACK    = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // Frame shifted out LSB first: data[7:0], odd parity, stop (1 = released).
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between the command source and ps2_host_tx.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, tx_busy, tx_done, tx_error, err_code
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, tx_busy, tx_done, tx_error, err_code
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer, stability filter, falling-edge pulse.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;

  // Idle bus is high, so everything resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked
// bit shifting, ack check and bus-idle wait, with start and packet timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int PACKET_TIMEOUT = 100000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  ps2_state_t  r_state, w_next;
  logic [31:0] r_cnt;
  logic [31:0] r_pkt;
  logic [3:0]  r_bit_cnt;
  logic [9:0]  r_shift;
  logic [1:0]  r_err, w_err_d;
  logic        r_clk_oe, r_dat_oe;
  logic        w_clk_oe_d, w_dat_oe_d;
  logic        w_clk_lvl, w_clk_fall;
  logic        w_dat_lvl, w_dat_fall_unused;
  logic        w_pkt_to;

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (ps2_dat_in),
    .o_level (w_dat_lvl),
    .o_fall  (w_dat_fall_unused)
  );

  assign w_pkt_to = (r_pkt == 32'(PACKET_TIMEOUT - 1));

  // State register and control counters; the reset releases both lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pkt     <= '0;
      r_bit_cnt <= '0;
      r_err     <= ERR_NONE;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_err    <= w_err_d;
      r_clk_oe <= w_clk_oe_d;
      r_dat_oe <= w_dat_oe_d;
      r_cnt    <= (w_next != r_state) ? '0 : r_cnt + 1;
      if (r_state inside {XFER, ACK, WAIT_IDLE}) r_pkt <= r_pkt + 1;
      else                                       r_pkt <= '0;
      if (w_next != r_state) r_bit_cnt <= '0;
      else if (w_clk_fall)   r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Frame shifter: bit 0 is always the next bit to put on the line.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.cmd_valid)
      r_shift <= ps2_frame(bus.cmd_data);
    else if (w_clk_fall && (r_state == RTS || r_state == XFER))
      r_shift <= {1'b1, r_shift[9:1]};
  end

  always_comb begin
    w_next  = r_state;
    w_err_d = r_err;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          w_next  = INHIBIT;
          w_err_d = ERR_NONE;
        end
      end
      INHIBIT: if (r_cnt == 32'(INHIBIT_CYCLES - 1)) w_next = RTS;
      RTS: begin
        if (w_clk_fall) begin
          w_next = XFER;
        end else if (r_cnt == 32'(START_TIMEOUT - 1)) begin
          w_next  = ERR;
          w_err_d = ERR_START_TO;
        end
      end
      XFER: begin
        if (w_pkt_to) begin
          w_next  = ERR;
          w_err_d = ERR_PACKET_TO;
        end else if (w_clk_fall && r_bit_cnt == 4'd8) begin
          w_next = ACK;
        end
      end
      ACK: begin
        if (w_pkt_to) begin
          w_next  = ERR;
          w_err_d = ERR_PACKET_TO;
        end else if (w_clk_fall) begin
          if (w_dat_lvl) begin
            w_next  = ERR;
            w_err_d = ERR_NO_ACK;
          end else begin
            w_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_pkt_to) begin
          w_next  = ERR;
          w_err_d = ERR_PACKET_TO;
        end else if (w_clk_lvl && w_dat_lvl) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Line drive for the coming cycle; start bit goes down one cycle before clock release.
  always_comb begin
    w_clk_oe_d = 1'b0;
    w_dat_oe_d = 1'b0;
    unique case (w_next)
      INHIBIT: begin
        w_clk_oe_d = 1'b1;
        w_dat_oe_d = (r_state == INHIBIT) && (r_cnt == 32'(INHIBIT_CYCLES - 2));
      end
      RTS:     w_dat_oe_d = 1'b1;
      XFER:    w_dat_oe_d = w_clk_fall ? ~r_shift[0] : r_dat_oe;
      default: ;
    endcase
  end

  assign ps2_clk_oe    = r_clk_oe;
  assign ps2_dat_oe    = r_dat_oe;
  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.tx_busy   = r_state inside {INHIBIT, RTS, XFER, ACK, WAIT_IDLE};
  assign bus.tx_done   = (r_state == DONE);
  assign bus.tx_error  = (r_state == ERR);
  assign bus.err_code  = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND bus with a clock-generating device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int ST   = 1500;
  localparam int PT   = 2500;
  localparam int FLT  = 4;
  localparam int HALF = 30;
  localparam int TCLK = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .PACKET_TIMEOUT (PT),
    .FILTER_CYCLES  (FLT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #(TCLK/2) clk = ~clk;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  int n_tests = 0;
  int n_fail  = 0;

  // Observers sampled on the falling edge.
  int   n_done = 0, n_err = 0, clk_run = 0, inh_len = 0;
  logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0, prev_err = 1'b0, prev_pulse = 1'b0;
  logic armed = 1'b0, ready_after = 1'b0;
  logic [1:0] oe_at_err = 2'b11;
  time  t_clk_rel = 0, t_first_dat = 0, t_err = 0;

  always @(negedge clk) begin
    prev_clk_oe <= ps2_clk_oe;
    prev_dat_oe <= ps2_dat_oe;
    prev_err    <= bus.tx_error;
    prev_pulse  <= bus.tx_done | bus.tx_error;
    if (bus.tx_done) n_done <= n_done + 1;
    if (bus.tx_error) n_err <= n_err + 1;
    if (bus.tx_error && !prev_err) begin
      t_err     <= $time;
      oe_at_err <= {ps2_clk_oe, ps2_dat_oe};
    end
    if (prev_pulse) ready_after <= bus.cmd_ready;
    if (ps2_clk_oe) clk_run <= clk_run + 1;
    else begin
      if (clk_run != 0) inh_len <= clk_run;
      clk_run <= 0;
    end
    if (prev_clk_oe && !ps2_clk_oe) begin
      t_clk_rel <= $time;
      armed     <= 1'b1;
    end else if (armed && prev_dat_oe && !ps2_dat_oe) begin
      t_first_dat <= $time;
      armed       <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    chk("ready_before_send", bus.cmd_ready, 1);
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, then clocks n_edges falling edges,
  // sampling the host's data on each rising edge; drives ack during edge 11.
  task automatic dev_xfer(input int n_edges, input logic ack_low, output logic [9:0] bits);
    int g;
    g    = 0;
    bits = '1;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("rts_seen", (g < 5000), 1);
    chk("busy_in_rts", bus.tx_busy, 1);
    repeat (20) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (e <= 10) bits[e-1] = ps2_dat_in;
      if (e == 10) begin
        repeat (HALF/2) @(negedge clk);
        dev_dat = ~ack_low;
        repeat (HALF - HALF/2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_ready(input int budget);
    int g;
    g = 0;
    while (bus.cmd_ready !== 1'b1 && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("idle_within_budget", (g < budget), 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       par;
    int         edges;
    logic       ack_low;
    logic       exp_done;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [9:0] bits;
    int d0, e0, tr;
    logic last;

    vecs[0] = '{8'hED, 1'b1, 11, 1'b1, 1'b1, 2'b00};
    vecs[1] = '{8'hF4, 1'b0, 11, 1'b1, 1'b1, 2'b00};
    vecs[2] = '{8'hFF, 1'b1, 11, 1'b1, 1'b1, 2'b00};
    vecs[3] = '{8'hED, 1'b1, 11, 1'b0, 1'b0, 2'b11};
    vecs[4] = '{8'h01, 1'b0, 11, 1'b1, 1'b1, 2'b00};

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_done", bus.tx_done, 0);
    chk("rst_error", bus.tx_error, 0);
    chk("rst_err_code", bus.err_code, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 5; i++) begin
      d0 = n_done;
      e0 = n_err;
      send(vecs[i].cmd);
      dev_xfer(vecs[i].edges, vecs[i].ack_low, bits);
      wait_ready(4000);
      chk("inhibit_len", inh_len, INH);
      chk("data_bits", bits[7:0], vecs[i].cmd);
      chk("parity_bit", bits[8], vecs[i].par);
      chk("stop_bit", bits[9], 1);
      chk("done_pulses", n_done - d0, vecs[i].exp_done);
      chk("err_pulses", n_err - e0, (vecs[i].exp_err != 2'b00));
      chk("err_code", bus.err_code, vecs[i].exp_err);
      chk("oe_released", {ps2_clk_oe, ps2_dat_oe}, 0);
      chk("ready_after_pulse", ready_after, 1);
    end

    // Device never clocks.
    e0 = n_err;
    send(8'hFF);
    dev_xfer(0, 1'b1, bits);
    wait_ready(4000);
    chk("start_to_err", n_err - e0, 1);
    chk("start_to_code", bus.err_code, 2'b01);
    chk("start_to_cycles", 32'((t_err - t_clk_rel) / TCLK), ST);
    chk("start_to_oe", oe_at_err, 0);

    // Device stops after five edges.
    e0 = n_err;
    send(8'hED);
    dev_xfer(5, 1'b1, bits);
    wait_ready(4000);
    chk("pkt_to_err", n_err - e0, 1);
    chk("pkt_to_code", bus.err_code, 2'b10);
    chk("pkt_to_cycles", 32'((t_err - t_first_dat) / TCLK), PT);
    chk("pkt_to_oe", oe_at_err, 0);

    // New request during a transfer is dropped.
    d0 = n_done;
    send(8'hF4);
    fork
      dev_xfer(11, 1'b1, bits);
      begin
        repeat (INH + 20 + 2*HALF) @(negedge clk);
        chk("ready_in_xfer", bus.cmd_ready, 0);
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.cmd_valid = 1'b0;
      end
    join
    wait_ready(4000);
    chk("ignored_data", bits[7:0], 8'hF4);
    chk("ignored_parity", bits[8], 0);
    chk("ignored_done", n_done - d0, 1);
    repeat (100) @(negedge clk);
    chk("no_queue_ready", bus.cmd_ready, 1);
    chk("no_queue_clk_oe", ps2_clk_oe, 0);

    // Asynchronous reset in the middle of a transfer.
    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    fork
      dev_xfer(11, 1'b1, bits);
      begin
        tr   = 0;
        last = ps2_dat_oe;
        for (int g = 0; g < 3000 && tr < 3; g++) begin
          @(negedge clk);
          if (ps2_dat_oe !== last) begin
            tr++;
            last = ps2_dat_oe;
          end
        end
        chk("xfer_reached", tr, 3);
        chk("busy_in_xfer", bus.tx_busy, 1);
        chk("dat_oe_before_rst", ps2_dat_oe, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 0);
        chk("async_rst_dat_oe", ps2_dat_oe, 0);
        chk("async_rst_ready", bus.cmd_ready, 1);
        chk("async_rst_busy", bus.tx_busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (50) @(negedge clk);
    chk("post_rst_no_done", n_done - d0, 0);
    chk("post_rst_no_err", n_err - e0, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(TCLK * 90000);
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1);
  end

endmodule
